// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
package tdm_pkg;

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    // A counter for n slots needs at least one bit even when n is small.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Serial word input and published-frame output of the TDM demultiplexer.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) ();

    localparam int SW = slot_w(NUM_CH);

    logic                 in_valid;
    logic                 in_sof;
    logic [DW-1:0]        in_data;
    logic [NUM_CH*DW-1:0] out_data;
    logic                 out_valid;
    logic [SW-1:0]        slot_idx;
    logic                 frame_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, slot_idx, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, slot_idx, frame_err
    );

endinterface

// File: rtl/tdm_demux.sv
// Collects a framed serial word stream into NUM_CH slots and publishes each
// complete frame atomically with a one-cycle strobe.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);

    localparam int            SW   = slot_w(NUM_CH);
    localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

    state_t               state, next_state;
    logic [SW-1:0]        slot_q, slot_next;
    logic [DW-1:0]        shadow [NUM_CH];
    logic [NUM_CH*DW-1:0] out_data_q, frame_next;
    logic                 out_valid_q, frame_err_q;
    logic                 wr_en;
    logic [SW-1:0]        wr_slot;
    logic                 publish;
    logic                 abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        slot_next  = slot_q;
        wr_en      = 1'b0;
        wr_slot    = slot_q;
        publish    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_sof) begin
                    wr_en      = 1'b1;
                    wr_slot    = '0;
                    slot_next  = SW'(1);
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (bus.in_sof) begin
                        // Early sof: drop the partial frame and restart at slot 0.
                        abort     = 1'b1;
                        wr_slot   = '0;
                        slot_next = SW'(1);
                    end else if (slot_q == LAST) begin
                        publish    = 1'b1;
                        slot_next  = '0;
                        next_state = IDLE;
                    end else begin
                        slot_next = slot_q + SW'(1);
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The last word goes straight into the published frame, bypassing shadow.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == NUM_CH - 1) begin
                frame_next[k*DW +: DW] = bus.in_data;
            end else begin
                frame_next[k*DW +: DW] = shadow[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            slot_q      <= slot_next;
            out_valid_q <= publish;
            frame_err_q <= abort;
            if (publish) begin
                out_data_q <= frame_next;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && (wr_slot == SW'(k))) begin
                    shadow[k] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot_idx  = slot_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with NUM_CH = 4, DW = 8.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tdm_demux_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

    tdm_demux #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge; return 1 ns after the
    // rising edge that samples it, when registered outputs have settled.
    task automatic applyStimulus(input logic valid, input logic sof, input logic [7:0] data);
        @(negedge clk);
        bus.in_valid = valid;
        bus.in_sof   = sof;
        bus.in_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    // Four consecutive words with sof on the first; checks slot progress and publish.
    task automatic sendFrame(input string tag, input logic [31:0] words);
        logic [7:0] w;
        for (int i = 0; i < NUM_CH; i++) begin
            w = words[i*8 +: 8];
            applyStimulus(1'b1, (i == 0), w);
            checkOutput({tag, "_slot"}, 32'(bus.slot_idx), 32'((i + 1) % NUM_CH));
            checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(i == NUM_CH - 1));
        end
        checkOutput({tag, "_data"}, bus.out_data, words);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;

        #12;
        checkOutput("rst_data", bus.out_data, 32'h0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_slot", 32'(bus.slot_idx), 32'h0);
        checkOutput("rst_err", 32'(bus.frame_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        sendFrame("basic", 32'h44332211);
        idleCycles(1);
        checkOutput("basic_pulse_end", 32'(bus.out_valid), 32'h0);
        checkOutput("basic_hold", bus.out_data, 32'h44332211);

        // Gapped frame: slot steps 1,2,3,0 and out_valid only after the last word.
        for (int i = 0; i < NUM_CH; i++) begin
            applyStimulus(1'b1, (i == 0), 8'(8'h11 * (i + 1)));
            checkOutput("gap_slot", 32'(bus.slot_idx), 32'((i + 1) % NUM_CH));
            checkOutput("gap_valid", 32'(bus.out_valid), 32'(i == NUM_CH - 1));
            if (i != NUM_CH - 1) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 1'b0, 8'hEE);
                    checkOutput("gap_idle_valid", 32'(bus.out_valid), 32'h0);
                    checkOutput("gap_idle_slot", 32'(bus.slot_idx), 32'(i + 1));
                end
            end
        end
        checkOutput("gap_data", bus.out_data, 32'h44332211);

        // Hunt: stray words without sof are dropped silently.
        applyStimulus(1'b1, 1'b0, 8'h55);
        checkOutput("hunt_slot0", 32'(bus.slot_idx), 32'h0);
        checkOutput("hunt_err0", 32'(bus.frame_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkOutput("hunt_slot1", 32'(bus.slot_idx), 32'h0);
        checkOutput("hunt_err1", 32'(bus.frame_err), 32'h0);
        sendFrame("hunt", 32'h04030201);

        // Back-to-back: second frame starts on the cycle after the first publishes.
        sendFrame("b2b_a", 32'h04030201);
        sendFrame("b2b_b", 32'h08070605);

        // Early sof aborts the AA/BB frame without touching out_data.
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 8'hAA);
        applyStimulus(1'b1, 1'b0, 8'hBB);
        checkOutput("early_err_quiet", 32'(bus.frame_err), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h01);
        checkOutput("early_err", 32'(bus.frame_err), 32'h1);
        checkOutput("early_slot", 32'(bus.slot_idx), 32'h1);
        checkOutput("early_hold", bus.out_data, 32'h08070605);
        checkOutput("early_novalid", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h02);
        checkOutput("early_err_end", 32'(bus.frame_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h03);
        applyStimulus(1'b1, 1'b0, 8'h04);
        checkOutput("early_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("early_data", bus.out_data, 32'h04030201);

        // Reset mid-frame takes effect without a clock edge.
        applyStimulus(1'b1, 1'b1, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h22);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n        = 1'b0;
        #1;
        checkOutput("midrst_data", bus.out_data, 32'h0);
        checkOutput("midrst_slot", 32'(bus.slot_idx), 32'h0);
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame("postrst", 32'hD4C3B2A1);
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: accepts a framed serial word stream on one input and distributes consecutive words to NUM_CH parallel output slots. It is the receive-side counterpart of the combinational selection muxes in the basic combinational library. A slot counter and frame-sync state machine replace the external select line. Completed frames are published atomically with a one-cycle strobe, for use behind any TDM link or time-sliced bus.

## Interface
- NUM_CH, 4, number of output slots per frame (>= 2)
- DW, 8, data width per word
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_sof  input  1  start of frame; marks word for slot 0
- in_data  input  DW  input word
- out_data  output  NUM_CH*DW  published frame; slot k at bits [k*DW +: DW]
- out_valid  output  1  one-cycle pulse: out_data just updated
- slot_idx  output  $clog2(NUM_CH)  slot the next accepted word fills
- frame_err  output  1  one-cycle pulse: frame aborted by early in_sof

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE (hunting for in_sof), COLLECT (filling slots 1..NUM_CH-1).
- Reset: state IDLE; slot_idx 0; shadow and out_data all zero; out_valid 0; frame_err 0.
- IDLE, in_valid & in_sof: in_data -> shadow slot 0, slot_idx <= 1, go COLLECT.
- IDLE, in_valid & !in_sof: word dropped, no error, stay IDLE (resync).
- COLLECT, in_valid & !in_sof: in_data -> shadow[slot_idx]; slot_idx++.
- COLLECT, last slot (slot_idx == NUM_CH-1) accepted: out_data <= shadow with last word merged in, out_valid pulses, slot_idx <= 0, go IDLE.
- COLLECT, in_valid & in_sof (early sof): frame_err pulses; partial frame discarded (out_data unchanged); new word -> shadow slot 0, slot_idx <= 1, stay COLLECT.
- in_valid low: no state change; gaps between words of any length are legal.
- Back-to-back frames: in_sof on the cycle after a last-slot word is accepted normally from IDLE.
- out_data only changes on frame completion and holds its value otherwise; it is never partially updated.
- For NUM_CH = 2^n, slot_idx wraps naturally; for other NUM_CH, an explicit compare at NUM_CH-1 is required. slot_idx never reaches NUM_CH.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the edge sampling the last slot word updates out_data and raises out_valid. Both are visible in the following cycle. out_valid is high for exactly 1 cycle.
- frame_err is raised by the edge sampling the early in_sof and is high for exactly 1 cycle.
- No backpressure: every valid word is consumed or dropped the same cycle.
- Reset asserted mid-frame: immediate return to reset values, and the partial frame is lost. The first in_sof after deassertion starts cleanly.

## Structure
- A shared package tdm_pkg holds the state enum (IDLE, COLLECT) and a SLOT_W = $clog2(NUM_CH) helper function.
- Single module. The slot counter and shadow register array stay inline; no sub-module is warranted.

## Test plan
- Reset then frame: sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> 1 cycle later out_data = 0x44332211, out_valid high for 1 cycle, slot_idx = 0.
- Gapped frame: same words with 3 idle cycles between each -> identical out_data; out_valid pulses only after 0x44; slot_idx steps 1, 2, 3, 0.
- Early sof: sof+0xAA, 0xBB, then sof+0x01, 0x02, 0x03, 0x04 -> frame_err pulses on the second sof; out_data = 0x04030201; 0xAA/0xBB never appear.
- Hunt: 0x55, 0x66 without sof, then a full frame 0x01..0x04 -> stray words dropped, no frame_err, out_data = 0x04030201.
- Back-to-back: two frames 0x01..0x04 then 0x05..0x08 with no gap -> two out_valid pulses 4 cycles apart; final out_data = 0x08070605.
- Reset mid-frame: rst_n low after 2 slots -> out_data = 0, slot_idx = 0, out_valid = 0 asynchronously; the next full frame is published correctly.
